// File: rtl/mult_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mult_pkg: widths, slot record and multiply helper shared by the   |
// | multiplication issue queue, issue unit and CDB arbiter.           |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package mult_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 5;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } mult_slot_t;

  // Signed product; only the low DATA_W bits are ever broadcast.
  function automatic logic [DATA_W-1:0] mult_lo(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = $signed(a) * $signed(b);
    return p[DATA_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mult_pipe: operand slot, multiply and product shift register      |
// | feeding the issue unit's result register.                         |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mult_pipe
  import mult_pkg::*;
#(
  parameter int N_STAGES = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              advance,
  input  logic              flush,
  input  logic              issue,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [TAG_W-1:0]  rd_tag,
  output mult_slot_t        last_slot,
  output logic              busy
);

  mult_slot_t        r_op;
  logic [DATA_W-1:0] r_rt;
  mult_slot_t        w_prod;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_op <= '0;
      r_rt <= '0;
    end else if (flush) begin
      r_op.valid <= 1'b0;
    end else if (advance) begin
      r_op <= '{valid: issue, tag: rd_tag, data: rs_data};
      r_rt <= rt_data;
    end
  end

  always_comb begin
    w_prod      = r_op;
    w_prod.data = mult_lo(r_op.data, r_rt);
  end

  // The result register in the top level is the final stage, so this block
  // holds N_STAGES-1 registers: the operand slot plus N_STAGES-2 product slots.
  generate
    if (N_STAGES > 2) begin : g_deep
      localparam int c_DEPTH = N_STAGES - 2;
      mult_slot_t         r_prod [c_DEPTH];
      logic [c_DEPTH-1:0] w_valids;

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          for (int i = 0; i < c_DEPTH; i++) r_prod[i] <= '0;
        end else if (flush) begin
          for (int i = 0; i < c_DEPTH; i++) r_prod[i].valid <= 1'b0;
        end else if (advance) begin
          r_prod[0] <= w_prod;
          for (int i = 1; i < c_DEPTH; i++) r_prod[i] <= r_prod[i-1];
        end
      end

      always_comb begin
        for (int i = 0; i < c_DEPTH; i++) w_valids[i] = r_prod[i].valid;
      end

      assign last_slot = r_prod[c_DEPTH-1];
      assign busy      = r_op.valid | (|w_valids);
    end else begin : g_shallow
      assign last_slot = w_prod;
      assign busy      = r_op.valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/issue_unit_mult.sv
`default_nettype none
// +------------------------------------------------------------------+
// | issue_unit_mult: takes ready multiply ops from the issue queue,   |
// | runs the fixed-latency multiply and requests the CDB for results. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module issue_unit_mult
  import mult_pkg::*;
#(
  parameter int N_STAGES = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              IssueQue_Ready,
  input  logic [DATA_W-1:0] IssueQue_Rs_Data,
  input  logic [DATA_W-1:0] IssueQue_Rt_Data,
  input  logic [TAG_W-1:0]  IssueQue_Rd_Tag,
  output logic              Issueblk_Issue,
  input  logic              RB_Flush_Valid,
  output logic              Mult_CDB_Req,
  input  logic              CDB_Grant,
  output logic              CDB_Valid,
  output logic [TAG_W-1:0]  CDB_Tag,
  output logic [DATA_W-1:0] CDB_Data,
  output logic              Mult_Busy
);

  mult_slot_t r_out;
  mult_slot_t w_last;
  logic       w_hold;
  logic       w_advance;
  logic       w_pipe_busy;

  assign w_hold    = r_out.valid & ~CDB_Grant;
  assign w_advance = ~w_hold;

  // Rst_n gates the issue so nothing is acknowledged while the block is held in reset.
  assign Issueblk_Issue = Rst_n & IssueQue_Ready & w_advance & ~RB_Flush_Valid;

  mult_pipe #(
    .N_STAGES (N_STAGES)
  ) u_pipe (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .advance   (w_advance),
    .flush     (RB_Flush_Valid),
    .issue     (Issueblk_Issue),
    .rs_data   (IssueQue_Rs_Data),
    .rt_data   (IssueQue_Rt_Data),
    .rd_tag    (IssueQue_Rd_Tag),
    .last_slot (w_last),
    .busy      (w_pipe_busy)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_out <= '0;
    end else if (RB_Flush_Valid) begin
      r_out.valid <= 1'b0;
    end else if (w_advance) begin
      r_out <= w_last;
    end
  end

  assign Mult_CDB_Req = r_out.valid;
  assign CDB_Valid    = r_out.valid & CDB_Grant & ~RB_Flush_Valid;
  assign CDB_Tag      = CDB_Valid ? r_out.tag  : '0;
  assign CDB_Data     = CDB_Valid ? r_out.data : '0;
  assign Mult_Busy    = r_out.valid | w_pipe_busy;

endmodule
`default_nettype wire

// File: tb/tb_issue_unit_mult.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_issue_unit_mult: directed vectors with a scoreboard queue.     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_issue_unit_mult;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        IssueQue_Ready = 1'b0;
  logic [15:0] IssueQue_Rs_Data = '0;
  logic [15:0] IssueQue_Rt_Data = '0;
  logic [4:0]  IssueQue_Rd_Tag = '0;
  logic        Issueblk_Issue;
  logic        RB_Flush_Valid = 1'b0;
  logic        Mult_CDB_Req;
  logic        CDB_Grant = 1'b0;
  logic        CDB_Valid;
  logic [4:0]  CDB_Tag;
  logic [15:0] CDB_Data;
  logic        Mult_Busy;

  issue_unit_mult #(
    .N_STAGES (4)
  ) dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .IssueQue_Ready   (IssueQue_Ready),
    .IssueQue_Rs_Data (IssueQue_Rs_Data),
    .IssueQue_Rt_Data (IssueQue_Rt_Data),
    .IssueQue_Rd_Tag  (IssueQue_Rd_Tag),
    .Issueblk_Issue   (Issueblk_Issue),
    .RB_Flush_Valid   (RB_Flush_Valid),
    .Mult_CDB_Req     (Mult_CDB_Req),
    .CDB_Grant        (CDB_Grant),
    .CDB_Valid        (CDB_Valid),
    .CDB_Tag          (CDB_Tag),
    .CDB_Data         (CDB_Data),
    .Mult_Busy        (Mult_Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  tag;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int to_cnt = 0;
  int to_seen = 0;

  // Expectations the stimulus arms for the monitor, changed only just after a rising edge.
  bit chk_issue = 0;
  bit exp_issue = 0;
  bit chk_busy  = 0;
  bit chk_zero  = 0;
  bit chk_end   = 0;

  always @(negedge Clk) begin
    exp_t e;
    if (to_cnt != to_seen) begin
      n_cmp++; n_err++;
      $display("FAIL handshake_timeout: %0d waits expired, required 0", to_cnt - to_seen);
      to_seen = to_cnt;
    end
    if (CDB_Valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_bcast @%0d: tag=%0d data=%h, required no broadcast", cyc, CDB_Tag, CDB_Data);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (CDB_Tag !== e.tag || CDB_Data !== e.data) begin
          n_err++;
          $display("FAIL bcast @%0d: tag=%0d data=%h, required tag=%0d data=%h", cyc, CDB_Tag, CDB_Data, e.tag, e.data);
        end
        if (e.due >= 0) begin
          n_cmp++;
          if (cyc != e.due) begin
            n_err++;
            $display("FAIL latency tag=%0d: cycle %0d, required %0d", e.tag, cyc, e.due);
          end
        end
      end
    end else begin
      n_cmp++;
      if (CDB_Tag !== '0 || CDB_Data !== '0) begin
        n_err++;
        $display("FAIL idle_gating @%0d: tag=%0d data=%h, required 0/0000", cyc, CDB_Tag, CDB_Data);
      end
    end
    if (chk_issue) begin
      n_cmp++;
      if (Issueblk_Issue !== exp_issue) begin
        n_err++;
        $display("FAIL issue @%0d: Issueblk_Issue=%b, required %b", cyc, Issueblk_Issue, exp_issue);
      end
    end
    if (chk_busy) begin
      n_cmp++;
      if (Mult_Busy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_idle @%0d: Mult_Busy=%b, required 0", cyc, Mult_Busy);
      end
    end
    if (chk_zero) begin
      n_cmp++;
      if ({Issueblk_Issue, Mult_CDB_Req, CDB_Valid, CDB_Tag, CDB_Data, Mult_Busy} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs @%0d: issue=%b req=%b valid=%b tag=%0d data=%h busy=%b, required all 0",
                 cyc, Issueblk_Issue, Mult_CDB_Req, CDB_Valid, CDB_Tag, CDB_Data, Mult_Busy);
      end
    end
    if (chk_end) begin
      n_cmp++;
      if (sb.size() != 0) begin
        n_err++;
        $display("FAIL lost_results: %0d outstanding, required 0", sb.size());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  // Offer one op until taken; push the expected broadcast when the issue is seen.
  task automatic offer(input logic [15:0] rs, input logic [15:0] rt, input logic [4:0] tag,
                       input logic [15:0] exp, input bit timed);
    int n;
    bit got;
    n = 0;
    got = 0;
    IssueQue_Ready   = 1'b1;
    IssueQue_Rs_Data = rs;
    IssueQue_Rt_Data = rt;
    IssueQue_Rd_Tag  = tag;
    while (!got && n < 40) begin
      @(negedge Clk);
      if (Issueblk_Issue) begin
        sb.push_back('{tag, exp, timed ? cyc + 4 : -1});
        got = 1;
      end
      @(posedge Clk); #1;
      n++;
    end
    IssueQue_Ready = 1'b0;
    if (!got) to_cnt++;
  endtask

  initial begin
    int n;
    bit seen;

    // Reset with live inputs: nothing may leak to the outputs.
    Rst_n = 1'b0; CDB_Grant = 1'b1; IssueQue_Ready = 1'b1;
    IssueQue_Rs_Data = 16'h0003; IssueQue_Rt_Data = 16'h0005; IssueQue_Rd_Tag = 5'd1;
    chk_zero = 1;
    idle(2);
    chk_zero = 0; IssueQue_Ready = 1'b0; Rst_n = 1'b1;
    idle(1);

    // Single op, then idle.
    offer(16'h0003, 16'h0005, 5'd7, 16'h000F, 1);
    idle(6);
    chk_busy = 1; idle(1); chk_busy = 0;

    // Signed operands and truncation.
    offer(16'hFFFF, 16'h0002, 5'd8,  16'hFFFE, 1);
    offer(16'h0100, 16'h0100, 5'd9,  16'h0000, 1);
    offer(16'h8000, 16'hFFFF, 5'd10, 16'h8000, 1);
    offer(16'hFFFD, 16'hFFFB, 5'd11, 16'h000F, 1);
    offer(16'h1234, 16'h0010, 5'd12, 16'h2340, 1);
    idle(6);

    // Back-to-back tags 1,2,3.
    offer(16'h0002, 16'h0003, 5'd1, 16'h0006, 1);
    offer(16'h0007, 16'h0007, 5'd2, 16'h0031, 1);
    offer(16'h00FF, 16'h00FF, 5'd3, 16'hFE01, 1);
    idle(6);

    // Backpressure: grant withheld while a result is waiting.
    offer(16'h0004, 16'h0004, 5'd13, 16'h0010, 0);
    offer(16'h0005, 16'h0005, 5'd14, 16'h0019, 0);
    CDB_Grant = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge Clk);
      seen = Mult_CDB_Req;
      @(posedge Clk); #1;
      n++;
    end
    if (!seen) to_cnt++;
    IssueQue_Ready = 1'b1; IssueQue_Rs_Data = 16'h0009; IssueQue_Rt_Data = 16'h0009;
    IssueQue_Rd_Tag = 5'd15; chk_issue = 1; exp_issue = 0;
    idle(3);
    chk_issue = 0; IssueQue_Ready = 1'b0; CDB_Grant = 1'b1;
    idle(2);
    offer(16'h0009, 16'h0009, 5'd15, 16'h0051, 1);
    idle(6);

    // Flush two cycles after the last issue, with the queue still offering.
    offer(16'h0006, 16'h0007, 5'd4, 16'h002A, 1);
    offer(16'h0002, 16'h0002, 5'd5, 16'h0004, 1);
    idle(1);
    RB_Flush_Valid = 1'b1; IssueQue_Ready = 1'b1;
    IssueQue_Rs_Data = 16'h0001; IssueQue_Rt_Data = 16'h0001; IssueQue_Rd_Tag = 5'd6;
    sb.delete();
    chk_issue = 1; exp_issue = 0;
    idle(1);
    RB_Flush_Valid = 1'b0; IssueQue_Ready = 1'b0; chk_issue = 0; chk_busy = 1;
    idle(1);
    chk_busy = 0;
    idle(6);

    // Reset with three ops in flight.
    offer(16'h0001, 16'h0002, 5'd16, 16'h0002, 1);
    offer(16'h0003, 16'h0003, 5'd17, 16'h0009, 1);
    offer(16'h0004, 16'h0004, 5'd18, 16'h0010, 1);
    Rst_n = 1'b0; IssueQue_Ready = 1'b1;
    sb.delete();
    chk_zero = 1;
    idle(2);
    chk_zero = 0; Rst_n = 1'b1; IssueQue_Ready = 1'b0;
    idle(8);
    chk_busy = 1; idle(1); chk_busy = 0;
    offer(16'h0007, 16'h0006, 5'd19, 16'h002A, 1);
    idle(6);

    chk_end = 1; idle(1); chk_end = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
